// File: rtl/hpdmc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hpdmc_pkg
// Description : Shared constants and FSM encoding for the HPDMC burst data path
// Revision    : 1.0 - initial release
// ============================================================================
package hpdmc_pkg;

   localparam int BURST_LEN_DEF = 4;
   localparam int CL_CYCLES_DEF = 3;
   localparam int DATA_W        = 64;
   localparam int MASK_W        = 8;
   localparam int LAT_W         = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WLOAD  = 3'd1,
      ST_WTAIL  = 3'd2,
      ST_RLAT   = 3'd3,
      ST_RDRAIN = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/hpdmc_beat_ctr.sv
`default_nettype none
// ============================================================================
// Module      : hpdmc_beat_ctr
// Description : Loadable down-counter with terminal-count flag; parks at zero
// Revision    : 1.0 - initial release
// ============================================================================
module hpdmc_beat_ctr #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   output logic [WIDTH-1:0] o_count,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_cnt;

   // Load has priority; decrement stops at zero so the counter rests at 0 between bursts
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_count = r_cnt;
   assign o_tc    = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/hpdmc_burst_dp.sv
`default_nettype none
// ============================================================================
// Module      : hpdmc_burst_dp
// Description : Bus-side burst data path in front of the DDR I/O stage.
//               Sequences one write or read burst per scheduler command.
// Revision    : 1.0 - initial release
// ============================================================================
module hpdmc_burst_dp
   import hpdmc_pkg::*;
#(
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int CL_CYCLES = CL_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_cmd_write,
   input  logic              i_cmd_read,
   output logic              o_busy,
   output logic              o_err_overlap,
   input  logic [DATA_W-1:0] i_fml_do,
   input  logic [MASK_W-1:0] i_fml_sel,
   output logic              o_fml_dw_ack,
   output logic [DATA_W-1:0] o_fml_di,
   output logic              o_fml_di_stb,
   output logic              o_op_write,
   output logic              o_op_read,
   output logic              o_buffer_w_load,
   output logic [MASK_W-1:0] o_buffer_w_mask,
   output logic [DATA_W-1:0] o_buffer_w_dat,
   output logic              o_buffer_r_next,
   output logic              o_buffer_r_nextburst,
   input  logic [DATA_W-1:0] i_buffer_r_dat
);

   localparam int BW = $clog2(BURST_LEN);

   // Write loads BURST_LEN-1 more beats after the entering cycle; read drains BURST_LEN beats
   localparam logic [BW-1:0] c_wr_beats   = BW'(BURST_LEN - 2);
   localparam logic [BW-1:0] c_rd_beats   = BW'(BURST_LEN - 1);
   localparam logic [LAT_W-1:0] c_lat     = LAT_W'(CL_CYCLES);
   // Read-burst cycle positions (0 = command cycle) bounding the op_read window
   localparam logic [4:0] c_rlat_base  = 5'(CL_CYCLES + 2);
   localparam logic [4:0] c_drain_base = 5'(CL_CYCLES + BURST_LEN + 2);
   localparam logic [4:0] c_opr_lo     = 5'(CL_CYCLES - 1);
   localparam logic [4:0] c_opr_hi     = 5'(CL_CYCLES + BURST_LEN - 2);

   state_t            r_state;
   state_t            w_state_next;
   logic              w_wload;
   logic              w_nextburst;
   logic              w_accept_wr;
   logic              w_accept_rd;
   logic              w_idle;
   logic              w_beat_load;
   logic [BW-1:0]     w_beat_val;
   logic [BW-1:0]     w_beat_cnt;
   logic              w_beat_tc;
   logic [LAT_W-1:0]  w_lat_cnt;
   logic              w_lat_tc;
   logic [4:0]        w_rd_pos;
   logic              w_rd_active;
   logic              w_op_read_next;
   logic              r_op_write;
   logic              r_op_read;
   logic [DATA_W-1:0] r_fml_di;
   logic              r_fml_di_stb;
   logic              r_err;

   assign w_idle      = (r_state == ST_IDLE);
   assign w_accept_wr = w_idle & i_cmd_write;
   assign w_accept_rd = w_idle & i_cmd_read & ~i_cmd_write;

   assign w_beat_load = w_accept_wr | ((r_state == ST_RLAT) & w_lat_tc);
   assign w_beat_val  = w_accept_wr ? c_wr_beats : c_rd_beats;

   hpdmc_beat_ctr #(.WIDTH(BW)) u_beat_ctr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_beat_load),
      .i_load_val (w_beat_val),
      .i_dec      ((r_state == ST_WLOAD) | (r_state == ST_RDRAIN)),
      .o_count    (w_beat_cnt),
      .o_tc       (w_beat_tc)
   );

   hpdmc_beat_ctr #(.WIDTH(LAT_W)) u_lat_ctr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_accept_rd),
      .i_load_val (c_lat),
      .i_dec      (r_state == ST_RLAT),
      .o_count    (w_lat_cnt),
      .o_tc       (w_lat_tc)
   );

   // Next-state and combinational handshakes; a simultaneous read loses to the write
   always_comb begin
      w_state_next = r_state;
      w_wload      = 1'b0;
      w_nextburst  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_cmd_write) begin
               w_state_next = ST_WLOAD;
               w_wload      = 1'b1;
            end else if (i_cmd_read) begin
               w_state_next = ST_RLAT;
               w_nextburst  = 1'b1;
            end
         end
         ST_WLOAD: begin
            w_wload = 1'b1;
            if (w_beat_tc) w_state_next = ST_WTAIL;
         end
         ST_WTAIL:  w_state_next = ST_IDLE;
         ST_RLAT:   if (w_lat_tc) w_state_next = ST_RDRAIN;
         ST_RDRAIN: if (w_beat_tc) w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // Position of the next cycle within a read burst, used to place the op_read window
   always_comb begin
      w_rd_pos    = 5'd0;
      w_rd_active = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_rd_pos    = 5'd1;
            w_rd_active = w_accept_rd;
         end
         ST_RLAT: begin
            w_rd_pos    = c_rlat_base - 5'(w_lat_cnt);
            w_rd_active = 1'b1;
         end
         ST_RDRAIN: begin
            w_rd_pos    = c_drain_base - 5'(w_beat_cnt);
            w_rd_active = 1'b1;
         end
         default: begin
            w_rd_pos    = 5'd0;
            w_rd_active = 1'b0;
         end
      endcase
   end

   assign w_op_read_next = w_rd_active && (w_rd_pos >= c_opr_lo) && (w_rd_pos <= c_opr_hi);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   // Registered I/O controls, read return path and sticky overlap error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_write   <= 1'b0;
         r_op_read    <= 1'b0;
         r_fml_di     <= '0;
         r_fml_di_stb <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_op_write   <= (w_state_next == ST_WLOAD) || (w_state_next == ST_WTAIL);
         r_op_read    <= w_op_read_next;
         r_fml_di_stb <= (r_state == ST_RDRAIN);
         if (r_state == ST_RDRAIN) r_fml_di <= i_buffer_r_dat;
         if ((!w_idle && (i_cmd_write || i_cmd_read)) || (i_cmd_write && i_cmd_read))
            r_err <= 1'b1;
      end
   end

   assign o_busy               = ~w_idle;
   assign o_err_overlap        = r_err;
   assign o_fml_dw_ack         = w_wload;
   assign o_buffer_w_load      = w_wload;
   assign o_buffer_w_dat       = i_fml_do;
   assign o_buffer_w_mask      = ~i_fml_sel;
   assign o_buffer_r_nextburst = w_nextburst;
   assign o_buffer_r_next      = (r_state == ST_RDRAIN);
   assign o_op_write           = r_op_write;
   assign o_op_read            = r_op_read;
   assign o_fml_di             = r_fml_di;
   assign o_fml_di_stb         = r_fml_di_stb;

endmodule
`default_nettype wire

// File: tb/tb_hpdmc_burst_dp.sv
`default_nettype none
// ============================================================================
// Module      : tb_hpdmc_burst_dp
// Description : Scoreboard bench for hpdmc_burst_dp with a cycle-level
//               reference model built from the burst timing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hpdmc_burst_dp;

   localparam int BL   = 4;
   localparam int CL   = 3;
   localparam int MAXC = 4096;
   localparam int INF  = 1 << 30;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_write, cmd_read;
   logic [63:0] fml_do;
   logic [7:0]  fml_sel;
   logic        busy, err_overlap, fml_dw_ack, fml_di_stb, op_write, op_read;
   logic        w_load, r_next, r_nextburst;
   logic [63:0] fml_di, w_dat, r_dat;
   logic [7:0]  w_mask;

   always #5 clk = ~clk;

   hpdmc_burst_dp #(.BURST_LEN(BL), .CL_CYCLES(CL)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .i_cmd_write          (cmd_write),
      .i_cmd_read           (cmd_read),
      .o_busy               (busy),
      .o_err_overlap        (err_overlap),
      .i_fml_do             (fml_do),
      .i_fml_sel            (fml_sel),
      .o_fml_dw_ack         (fml_dw_ack),
      .o_fml_di             (fml_di),
      .o_fml_di_stb         (fml_di_stb),
      .o_op_write           (op_write),
      .o_op_read            (op_read),
      .o_buffer_w_load      (w_load),
      .o_buffer_w_mask      (w_mask),
      .o_buffer_w_dat       (w_dat),
      .o_buffer_r_next      (r_next),
      .o_buffer_r_nextburst (r_nextburst),
      .i_buffer_r_dat       (r_dat)
   );

   // I/O read FIFO model: head pointer rewound by nextburst, advanced by next
   logic [63:0] rd_mem [4];
   logic [1:0]  rd_ptr = 2'd0;
   assign r_dat = rd_mem[rd_ptr];
   always @(posedge clk) begin
      if (r_nextburst)  rd_ptr <= 2'd0;
      else if (r_next)  rd_ptr <= rd_ptr + 2'd1;
   end

   // Expected per-cycle control values and expected data streams
   bit e_load [MAXC];
   bit e_opw  [MAXC];
   bit e_opr  [MAXC];
   bit e_nb   [MAXC];
   bit e_rn   [MAXC];
   bit e_stb  [MAXC];
   bit e_busy [MAXC];
   logic [71:0] exp_wq [$];
   logic [63:0] exp_rq [$];
   logic [71:0] drv_beats [$];

   int cyc = -1;
   int busy_end = 0;
   int err_at = INF;
   int n_vec = 0;
   int n_err = 0;
   bit mon_en = 1'b0;
   bit rnd_rd = 1'b1;
   bit rnd_wr = 1'b1;
   logic [63:0] wdat [4];
   logic [7:0]  wsel [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compares every output each cycle and pops the scoreboard on data beats
   always @(negedge clk) begin
      if (mon_en && cyc >= 0 && cyc < MAXC) begin
         chk("w_load", 64'(w_load), 64'(e_load[cyc]));
         chk("dw_ack", 64'(fml_dw_ack), 64'(e_load[cyc]));
         chk("op_write", 64'(op_write), 64'(e_opw[cyc]));
         chk("op_read", 64'(op_read), 64'(e_opr[cyc]));
         chk("nextburst", 64'(r_nextburst), 64'(e_nb[cyc]));
         chk("r_next", 64'(r_next), 64'(e_rn[cyc]));
         chk("di_stb", 64'(fml_di_stb), 64'(e_stb[cyc]));
         chk("busy", 64'(busy), 64'(e_busy[cyc]));
         chk("err_overlap", 64'(err_overlap), 64'(cyc >= err_at));
         if (w_load && e_load[cyc]) begin
            if (exp_wq.size() == 0) chk("wq_underflow", 64'd1, 64'd0);
            else begin
               logic [71:0] e;
               e = exp_wq.pop_front();
               chk("w_dat", w_dat, e[71:8]);
               chk("w_mask", 64'(w_mask), 64'(e[7:0]));
            end
         end
         if (fml_di_stb && e_stb[cyc]) begin
            if (exp_rq.size() == 0) chk("rq_underflow", 64'd1, 64'd0);
            else chk("fml_di", fml_di, exp_rq.pop_front());
         end
         if (rst) chk("di_in_reset", fml_di, 64'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      cmd_write = 1'b0;
      cmd_read  = 1'b0;
      if (drv_beats.size() != 0) {fml_do, fml_sel} = drv_beats.pop_front();
      else begin
         fml_do  = {$urandom, $urandom};
         fml_sel = 8'($urandom);
      end
   endtask

   task automatic mark(input int t, input int kind);
      if (t < MAXC) begin
         case (kind)
            0: e_load[t] = 1'b1;
            1: e_opw[t]  = 1'b1;
            2: e_opr[t]  = 1'b1;
            3: e_nb[t]   = 1'b1;
            4: e_rn[t]   = 1'b1;
            5: e_stb[t]  = 1'b1;
            default: e_busy[t] = 1'b1;
         endcase
      end
   endtask

   // Issue a command in the current cycle and record what the spec says must follow
   task automatic issue(input bit w, input bit r);
      int t;
      t = cyc;
      cmd_write = w;
      cmd_read  = r;
      if (w && r && err_at > t + 1) err_at = t + 1;
      if (t < busy_end) begin
         if ((w || r) && err_at > t + 1) err_at = t + 1;
      end else if (w) begin
         for (int j = 0; j < BL; j++) begin
            if (rnd_wr) begin
               wdat[j] = {$urandom, $urandom};
               wsel[j] = 8'($urandom);
            end
            exp_wq.push_back({wdat[j], ~wsel[j]});
            if (j > 0) drv_beats.push_back({wdat[j], wsel[j]});
            mark(t + j, 0);
            mark(t + 1 + j, 1);
            mark(t + 1 + j, 6);
         end
         fml_do  = wdat[0];
         fml_sel = wsel[0];
         busy_end = t + BL + 1;
      end else if (r) begin
         mark(t, 3);
         for (int j = 0; j < BL; j++) begin
            if (rnd_rd) rd_mem[j] = {$urandom, $urandom};
            exp_rq.push_back(rd_mem[j]);
            mark(t + CL - 1 + j, 2);
            mark(t + CL + 2 + j, 4);
            mark(t + CL + 3 + j, 5);
         end
         for (int j = 1; j <= CL + BL + 1; j++) mark(t + j, 6);
         busy_end = t + CL + BL + 2;
      end
   endtask

   task automatic wait_idle();
      while (cyc < busy_end && cyc < MAXC - 40) step();
   endtask

   // Assert reset in the current cycle: everything pending is abandoned
   task automatic do_reset();
      rst = 1'b1;
      for (int i = cyc; i < MAXC; i++) begin
         if (i >= 0) begin
            e_load[i] = 0; e_opw[i] = 0; e_opr[i] = 0; e_nb[i] = 0;
            e_rn[i] = 0; e_stb[i] = 0; e_busy[i] = 0;
         end
      end
      exp_wq.delete();
      exp_rq.delete();
      drv_beats.delete();
      err_at   = INF;
      busy_end = cyc;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; cmd_write = 1'b0; cmd_read = 1'b0;
      fml_do = '0; fml_sel = '0;
      for (int k = 0; k < 4; k++) rd_mem[k] = '0;
      step();
      mon_en = 1'b1;
      step();
      rst = 1'b0;
      step(); step();

      // Directed write with fixed beats
      rnd_wr = 1'b0;
      wdat[0] = 64'h1111_1111_1111_1111; wsel[0] = 8'hFF;
      wdat[1] = 64'h2222_2222_2222_2222; wsel[1] = 8'h0F;
      wdat[2] = 64'h3333_3333_3333_3333; wsel[2] = 8'hFF;
      wdat[3] = 64'h4444_4444_4444_4444; wsel[3] = 8'h00;
      issue(1, 0);
      wait_idle();
      rnd_wr = 1'b1;
      step();

      // Directed read with A0+k at pointer k
      rnd_rd = 1'b0;
      for (int k = 0; k < 4; k++) rd_mem[k] = 64'hA0 + 64'(k);
      issue(0, 1);
      wait_idle();
      rnd_rd = 1'b1;
      step();

      // Read arriving two cycles into a write
      issue(1, 0);
      step(); step();
      issue(0, 1);
      wait_idle();
      step();

      // Write and read together
      issue(1, 1);
      wait_idle();

      // Write, then read in the first idle cycle, then reset mid-read
      issue(1, 0);
      wait_idle();
      issue(0, 1);
      for (int k = 0; k < 7; k++) step();
      do_reset();
      step(); step();

      // Random traffic, including commands landing while busy
      for (int n = 0; n < 60; n++) begin
         int g, kind;
         g = $urandom_range(0, BL + CL + 3);
         for (int k = 0; k < g; k++) step();
         kind = $urandom_range(0, 9);
         if (kind < 5)      issue(1, 0);
         else if (kind < 9) issue(0, 1);
         else               issue(1, 1);
         step();
         if (n == 30) begin
            wait_idle();
            do_reset();
            step();
         end
      end
      wait_idle();
      step(); step(); step();
      chk("wq_drained", 64'(exp_wq.size()), 64'd0);
      chk("rq_drained", 64'(exp_rq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
